branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor for the 5-stage in-order core: a direct-mapped branch target buffer with 2-bit saturating counters, read in IF to steer fetch and trained in EX from the resolved `branch_taken` outcome of the branch comparator. It detects mispredictions in EX and supplies the flush/redirect request and the corrected PC to the fetch stage. It is the consumer side of the branch-resolution interface.

## Interface
- `ENTRIES`, 16, BTB entries; power of two, 2..256
- `IDX_W`, $clog2(ENTRIES), index width (derived, not overridden)
- `clk` input 1, core clock
- `rst_n` input 1, synchronous active-low reset
- `if_pc` input 32, PC currently being fetched
- `pred_taken` output 1, predict taken for `if_pc`
- `pred_target` output 32, predicted target (`if_pc`+4 when not taken)
- `ex_valid` input 1, EX holds a live instruction (low on bubble/stall)
- `ex_branch` input 1, EX instruction is a conditional branch
- `ex_pc` input 32, PC of EX instruction
- `ex_taken` input 1, resolved outcome (`branch_taken`)
- `ex_target` input 32, resolved branch target
- `ex_pred_taken` input 1, prediction carried down the pipe from IF
- `ex_pred_target` input 32, predicted target carried from IF
- `mispredict` output 1, flush IF/ID and redirect
- `redirect_pc` output 32, corrected fetch PC
- `perf_branches` output 32, resolved-branch count
- `perf_mispredicts` output 32, misprediction count

## Operation
- Entry: `valid`, `tag` = PC[31:IDX_W+2], `target`[31:0], `ctr`[1:0]. Index = PC[IDX_W+1:2].
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Predict (combinational from `if_pc`): hit = valid && tag match; `pred_taken` = hit && ctr[1]; `pred_target` = `pred_taken` ? target : `if_pc`+4 (32-bit wrap).
- Update, when `ex_valid && ex_branch`, indexed by `ex_pc`:
  - hit: ctr saturating +1 if `ex_taken`, −1 otherwise; target <= `ex_target` if `ex_taken`.
  - miss and `ex_taken`: allocate; valid=1, tag, target, ctr=10 (replaces any occupant).
  - miss and not taken: no write.
- Mispredict:
  - branch: `ex_valid && ex_branch && (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target))`.
  - alias: `ex_valid && !ex_branch && ex_pred_taken`; also clears valid of the `ex_pc` entry if its tag matches.
- `redirect_pc` = (`ex_branch && ex_taken`) ? `ex_target` : `ex_pc`+4. Only meaningful when `mispredict`=1, otherwise driven `ex_pc`+4.
- `ex_valid`=0: no update, `mispredict`=0.

## Timing
- Prediction: zero latency, combinational from registered table.
- Mispredict/redirect: combinational in the EX cycle. The fetch stage registers them.
- Table/counter writes take effect at the next rising `clk`. An IF read of the index written in the same cycle returns the old contents.
- Reset (`rst_n`=0 at a rising edge, including mid-stream): all valid=0, ctr=01, target=0, perf counters=0.
  - While `rst_n`=0: `pred_taken`=0, `mispredict`=0, `pred_target`=`if_pc`+4.
  - Updates presented in the reset cycle are dropped.
- Perf counters increment at the clock edge following a qualifying EX cycle and wrap at 2^32.

## Configuration
- `BP_PERF_CNT_EN` defined:
  - `perf_branches` increments on each `ex_valid && ex_branch`.
  - `perf_mispredicts` increments on each `mispredict` cycle.
- `BP_PERF_CNT_EN` undefined: both ports remain and are tied to 0, and no counter flops are built.

## Structure
- `bp_pkg`: counter enum (`SNT`, `WNT`, `WT`, `ST`), reset counter value `WNT`, allocate value `WT`, `btb_entry_t` struct.
- Sub-module `bp_sat_counter2`: combinational 2-bit saturating next-state (inputs ctr, taken; output next ctr), instantiated in the update path.

## Test plan
- Reset, then `if_pc`=0x100 → `pred_taken`=0, `pred_target`=0x104. Both perf counters read 0.
- EX: `ex_pc`=0x100, branch, taken, target 0x80, pred 0 → `mispredict`=1, `redirect_pc`=0x80. Next cycle `if_pc`=0x100 → `pred_taken`=1, `pred_target`=0x80.
- Same branch resolved not-taken twice from ctr=10 → first predicts taken (ctr 10→01), second predicts not-taken. Not-taken again keeps ctr at 00. Four taken outcomes saturate at 11.
- Alias: after allocating 0x100 (ENTRIES=16), present `ex_pc`=0x100 non-branch with `ex_pred_taken`=1 → `mispredict`=1, `redirect_pc`=0x104, entry invalidated. Present 0x140 (same index, different tag) → miss.
- Same-cycle read/write: `if_pc`=0x200 while EX allocates 0x200 → `pred_taken`=0 that cycle, 1 the next cycle. Assert `rst_n`=0 one cycle → all predictions 0.
- `BP_PERF_CNT_EN` defined: 5 branches with 2 mispredicts → 5/2. Undefined → both 0.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: 2-bit counter states, BTB entry layout, tag helper.
// Pure declarations, no logic or timing of its own.
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_RST   = WNT;
    localparam ctr_e CTR_ALLOC = WT;

    localparam int PC_W  = 32;
    localparam int TAG_W = 30;

    // Tag is stored right-aligned; the upper bits stay zero for larger tables.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [PC_W-1:0]  target;
        ctr_e             ctr;
    } btb_entry_t;

    function automatic logic [TAG_W-1:0] pc_tag(input logic [PC_W-1:0] pc, input int idx_w);
        logic [PC_W-1:0] w_sh;
        w_sh = pc >> (idx_w + 2);
        return w_sh[TAG_W-1:0];
    endfunction

endpackage

// File: rtl/bp_if.sv
// Branch-resolution bundle between the EX stage (master) and the predictor (slave).
// Combinational: mispredict/redirect_pc respond in the same EX cycle; no handshake.
interface bp_ex_if;
    logic        ex_valid;
    logic        ex_branch;
    logic [31:0] ex_pc;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;

    modport master (
        output ex_valid, ex_branch, ex_pc, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        input  mispredict, redirect_pc
    );

    modport slave (
        input  ex_valid, ex_branch, ex_pc, ex_taken, ex_target,
               ex_pred_taken, ex_pred_target,
        output mispredict, redirect_pc
    );
endinterface

// File: rtl/bp_sat_counter2.sv
// 2-bit saturating counter next-state: up on taken, down on not-taken, clamps at SNT/ST.
// Latency: combinational. Backpressure: none.
module bp_sat_counter2
    import bp_pkg::*;
(
    input  ctr_e i_ctr,
    input  logic i_taken,
    output ctr_e o_ctr
);

    always_comb begin
        o_ctr = i_ctr;
        if (i_taken) begin
            if (i_ctr != ST) begin
                o_ctr = ctr_e'(i_ctr + 2'd1);
            end
        end else if (i_ctr != SNT) begin
            o_ctr = ctr_e'(i_ctr - 2'd1);
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB + 2-bit counters: IF prediction, EX training and mispredict redirect.
// Latency: prediction and redirect combinational; table writes visible after the next clk edge.
// Backpressure: none, EX stalls by dropping ex_valid. Perf counters built only with BP_PERF_CNT_EN.
module branch_predictor
    import bp_pkg::*;
#(
    parameter  int ENTRIES = 16,
    localparam int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    bp_ex_if.slave      ex,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispredicts
);

    btb_entry_t r_btb [ENTRIES];

    logic [IDX_W-1:0] w_if_idx;
    btb_entry_t       w_if_ent;
    logic             w_if_hit;

    logic [IDX_W-1:0] w_ex_idx;
    btb_entry_t       w_ex_ent;
    logic             w_ex_hit;
    ctr_e             w_ctr_nxt;

    logic             w_upd;
    logic             w_br_mp;
    logic             w_alias_mp;
    logic             w_mispredict;
    logic             w_wr_en;
    btb_entry_t       w_wr_ent;

    // ---------------- IF-side prediction ----------------
    assign w_if_idx = if_pc[IDX_W+1:2];
    assign w_if_ent = r_btb[w_if_idx];
    assign w_if_hit = w_if_ent.valid && (w_if_ent.tag == pc_tag(if_pc, IDX_W));

    assign pred_taken  = rst_n && w_if_hit && w_if_ent.ctr[1];
    assign pred_target = pred_taken ? w_if_ent.target : (if_pc + 32'd4);

    // ---------------- EX-side resolution ----------------
    assign w_ex_idx = ex.ex_pc[IDX_W+1:2];
    assign w_ex_ent = r_btb[w_ex_idx];
    assign w_ex_hit = w_ex_ent.valid && (w_ex_ent.tag == pc_tag(ex.ex_pc, IDX_W));
    assign w_upd    = ex.ex_valid && ex.ex_branch;

    bp_sat_counter2 u_ctr (
        .i_ctr   (w_ex_ent.ctr),
        .i_taken (ex.ex_taken),
        .o_ctr   (w_ctr_nxt)
    );

    assign w_br_mp = w_upd &&
                     ((ex.ex_taken != ex.ex_pred_taken) ||
                      (ex.ex_taken && (ex.ex_target != ex.ex_pred_target)));
    // A non-branch predicted taken means the BTB entry aliased onto ordinary code.
    assign w_alias_mp   = ex.ex_valid && !ex.ex_branch && ex.ex_pred_taken;
    assign w_mispredict = rst_n && (w_br_mp || w_alias_mp);

    assign ex.mispredict  = w_mispredict;
    assign ex.redirect_pc = (w_mispredict && ex.ex_branch && ex.ex_taken) ?
                            ex.ex_target : (ex.ex_pc + 32'd4);

    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_ent = w_ex_ent;
        if (w_upd) begin
            if (w_ex_hit) begin
                w_wr_en      = 1'b1;
                w_wr_ent.ctr = w_ctr_nxt;
                if (ex.ex_taken) begin
                    w_wr_ent.target = ex.ex_target;
                end
            end else if (ex.ex_taken) begin
                w_wr_en         = 1'b1;
                w_wr_ent.valid  = 1'b1;
                w_wr_ent.tag    = pc_tag(ex.ex_pc, IDX_W);
                w_wr_ent.target = ex.ex_target;
                w_wr_ent.ctr    = CTR_ALLOC;
            end
        end else if (w_alias_mp && w_ex_hit) begin
            w_wr_en        = 1'b1;
            w_wr_ent.valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_btb[i].valid  <= 1'b0;
                r_btb[i].tag    <= '0;
                r_btb[i].target <= '0;
                r_btb[i].ctr    <= CTR_RST;
            end
        end else if (w_wr_en) begin
            r_btb[w_ex_idx] <= w_wr_ent;
        end
    end

    // ---------------- Performance counters ----------------
`ifdef BP_PERF_CNT_EN
    logic [31:0] r_perf_br;
    logic [31:0] r_perf_mp;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_br <= '0;
            r_perf_mp <= '0;
        end else begin
            if (w_upd) begin
                r_perf_br <= r_perf_br + 32'd1;
            end
            if (w_mispredict) begin
                r_perf_mp <= r_perf_mp + 32'd1;
            end
        end
    end

    assign perf_branches    = r_perf_br;
    assign perf_mispredicts = r_perf_mp;
`else
    assign perf_branches    = '0;
    assign perf_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed table-driven bench for branch_predictor (ENTRIES=16): prediction, training, alias, reset, perf.
module tb_branch_predictor;
    logic        clk;
    logic        rst_n;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;

    int n_tests = 0;
    int n_fail  = 0;

    bp_ex_if ex_if ();

    branch_predictor #(.ENTRIES(16)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .ex               (ex_if),
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ifpc;
        logic        exv;
        logic        exb;
        logic [31:0] expc;
        logic        ext;
        logic [31:0] extgt;
        logic        exptk;
        logic [31:0] exptgt;
        logic        e_ptk;
        logic [31:0] e_ptgt;
        logic        e_mp;
        logic [31:0] e_rpc;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(
        input logic [31:0] ifpc, input logic exv, input logic exb, input logic [31:0] expc,
        input logic ext, input logic [31:0] extgt, input logic exptk, input logic [31:0] exptgt,
        input logic e_ptk, input logic [31:0] e_ptgt, input logic e_mp, input logic [31:0] e_rpc);
        vec_t v;
        v.ifpc = ifpc; v.exv = exv; v.exb = exb; v.expc = expc;
        v.ext = ext; v.extgt = extgt; v.exptk = exptk; v.exptgt = exptgt;
        v.e_ptk = e_ptk; v.e_ptgt = e_ptgt; v.e_mp = e_mp; v.e_rpc = e_rpc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] ifpc, input logic exv, input logic exb,
                         input logic [31:0] expc, input logic ext, input logic [31:0] extgt,
                         input logic exptk, input logic [31:0] exptgt);
        if_pc                = ifpc;
        ex_if.ex_valid       = exv;
        ex_if.ex_branch      = exb;
        ex_if.ex_pc          = expc;
        ex_if.ex_taken       = ext;
        ex_if.ex_target      = extgt;
        ex_if.ex_pred_taken  = exptk;
        ex_if.ex_pred_target = exptgt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic [31:0] ifpc);
        drive(ifpc, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        logic [31:0] exp_br;
        logic [31:0] exp_mp;

        rst_n = 1'b0;
        idle(32'h100);
        step();
        step();

        // Reset-state checks while rst_n is still low.
        @(negedge clk);
        check("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        check("rst_pred_target", pred_target, 32'h104);
        check("rst_mispredict", {31'd0, ex_if.mispredict}, 32'd0);
        check("rst_perf_br", perf_branches, 32'd0);
        check("rst_perf_mp", perf_mispredicts, 32'd0);
        step();
        rst_n = 1'b1;

        //         ifpc          exv   exb   expc    ext   extgt   ptk   ptgt    e_ptk e_ptgt  e_mp  e_rpc
        vt.push_back(mk(32'h100, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h104, 1'b0, 32'h0));
        vt.push_back(mk(32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h80,  1'b0, 32'h0,   1'b0, 32'h104, 1'b1, 32'h80));
        vt.push_back(mk(32'h100, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h80,  1'b0, 32'h0));
        vt.push_back(mk(32'h100, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   1'b1, 32'h80,  1'b1, 32'h80,  1'b1, 32'h104));
        vt.push_back(mk(32'h100, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h104, 1'b0, 32'h0));
        vt.push_back(mk(32'h100, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h104, 1'b0, 32'h0));
        vt.push_back(mk(32'h100, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h104, 1'b0, 32'h0));
        vt.push_back(mk(32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h80,  1'b0, 32'h0,   1'b0, 32'h104, 1'b1, 32'h80));
        vt.push_back(mk(32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h80,  1'b0, 32'h0,   1'b0, 32'h104, 1'b1, 32'h80));
        vt.push_back(mk(32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h80,  1'b1, 32'h80,  1'b1, 32'h80,  1'b0, 32'h0));
        vt.push_back(mk(32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h80,  1'b1, 32'h80,  1'b1, 32'h80,  1'b0, 32'h0));
        vt.push_back(mk(32'h100, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0,   1'b1, 32'h80,  1'b1, 32'h80,  1'b1, 32'h104));
        vt.push_back(mk(32'h100, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h80,  1'b0, 32'h0));
        vt.push_back(mk(32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h300, 1'b1, 32'h80,  1'b1, 32'h80,  1'b1, 32'h300));
        vt.push_back(mk(32'h100, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h300, 1'b0, 32'h0));
        vt.push_back(mk(32'h100, 1'b1, 1'b0, 32'h100, 1'b0, 32'h0,   1'b1, 32'h300, 1'b1, 32'h300, 1'b1, 32'h104));
        vt.push_back(mk(32'h100, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h104, 1'b0, 32'h0));
        vt.push_back(mk(32'h100, 1'b1, 1'b1, 32'h100, 1'b1, 32'h80,  1'b0, 32'h0,   1'b0, 32'h104, 1'b1, 32'h80));
        vt.push_back(mk(32'h140, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h144, 1'b0, 32'h0));
        vt.push_back(mk(32'h100, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h80,  1'b0, 32'h0));
        vt.push_back(mk(32'h100, 1'b1, 1'b0, 32'h140, 1'b0, 32'h0,   1'b1, 32'h80,  1'b1, 32'h80,  1'b1, 32'h144));
        vt.push_back(mk(32'h100, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h80,  1'b0, 32'h0));
        vt.push_back(mk(32'h100, 1'b0, 1'b1, 32'h100, 1'b1, 32'h500, 1'b0, 32'h0,   1'b1, 32'h80,  1'b0, 32'h0));
        vt.push_back(mk(32'h100, 1'b1, 1'b0, 32'h180, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h80,  1'b0, 32'h0));
        vt.push_back(mk(32'h100, 1'b1, 1'b1, 32'h200, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h80,  1'b0, 32'h0));
        vt.push_back(mk(32'h100, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h80,  1'b0, 32'h0));
        vt.push_back(mk(32'h200, 1'b1, 1'b1, 32'h200, 1'b1, 32'h400, 1'b0, 32'h0,   1'b0, 32'h204, 1'b1, 32'h400));
        vt.push_back(mk(32'h200, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h400, 1'b0, 32'h0));
        vt.push_back(mk(32'h100, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h104, 1'b0, 32'h0));
        vt.push_back(mk(32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0,   1'b0, 32'h0));

        foreach (vt[i]) begin
            drive(vt[i].ifpc, vt[i].exv, vt[i].exb, vt[i].expc, vt[i].ext, vt[i].extgt,
                  vt[i].exptk, vt[i].exptgt);
            @(negedge clk);
            check($sformatf("v%0d_pred_taken", i), {31'd0, pred_taken}, {31'd0, vt[i].e_ptk});
            check($sformatf("v%0d_pred_target", i), pred_target, vt[i].e_ptgt);
            check($sformatf("v%0d_mispredict", i), {31'd0, ex_if.mispredict}, {31'd0, vt[i].e_mp});
            if (vt[i].e_mp) begin
                check($sformatf("v%0d_redirect_pc", i), ex_if.redirect_pc, vt[i].e_rpc);
            end
            step();
        end

        // Mid-stream reset: 0x200 currently hits; an allocation presented during reset is dropped.
        rst_n = 1'b0;
        drive(32'h200, 1'b1, 1'b1, 32'h240, 1'b1, 32'h40, 1'b0, 32'h0);
        @(negedge clk);
        check("midrst_pred_taken", {31'd0, pred_taken}, 32'd0);
        check("midrst_pred_target", pred_target, 32'h204);
        check("midrst_mispredict", {31'd0, ex_if.mispredict}, 32'd0);
        step();
        rst_n = 1'b1;
        idle(32'h200);
        @(negedge clk);
        check("postrst_200_taken", {31'd0, pred_taken}, 32'd0);
        check("postrst_200_target", pred_target, 32'h204);
        check("postrst_perf_br", perf_branches, 32'd0);
        check("postrst_perf_mp", perf_mispredicts, 32'd0);
        idle(32'h240);
        @(negedge clk);
        check("postrst_240_taken", {31'd0, pred_taken}, 32'd0);
        step();

        // Five branches, two of them mispredicted (the two taken misses).
        for (int k = 0; k < 3; k++) begin
            drive(32'h0, 1'b1, 1'b1, 32'h500, 1'b0, 32'h0, 1'b0, 32'h0);
            step();
        end
        drive(32'h0, 1'b1, 1'b1, 32'h500, 1'b1, 32'h20, 1'b0, 32'h0);
        step();
        drive(32'h0, 1'b1, 1'b1, 32'h600, 1'b1, 32'h30, 1'b0, 32'h0);
        step();
        idle(32'h500);
        @(negedge clk);
`ifdef BP_PERF_CNT_EN
        exp_br = 32'd5;
        exp_mp = 32'd2;
`else
        exp_br = 32'd0;
        exp_mp = 32'd0;
`endif
        check("perf_branches", perf_branches, exp_br);
        check("perf_mispredicts", perf_mispredicts, exp_mp);
        // 0x600 replaced the 0x500 occupant of index 0.
        check("perf_seq_500_taken", {31'd0, pred_taken}, 32'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
